// File: rtl/lsu_pkg.sv
// lsu_pkg: access sizes, FSM states and word geometry shared by the load/store unit
package lsu_pkg;
   localparam int WORD_BYTES  = 8;
   localparam int OFFSET_BITS = 3;
   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;
   typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_e;
   function automatic logic [OFFSET_BITS-1:0] align_mask(size_e s);
      return OFFSET_BITS'((1 << s) - 1);
   endfunction
endpackage

// File: rtl/lsu_load_extract.sv
// lsu_load_extract: selects the addressed lanes of a memory word and sign/zero-extends them
module lsu_load_extract
   import lsu_pkg::*;
#(
   parameter int DATA_WIDTH = 64
) (
   input  logic [DATA_WIDTH-1:0]  word,
   input  logic [OFFSET_BITS-1:0] offset,
   input  size_e                  size,
   input  logic                   zext,
   output logic [DATA_WIDTH-1:0]  data
);
   logic [DATA_WIDTH-1:0] sh;
   assign sh = word >> {offset, 3'b000};
   always_comb
      data = size == SZ_B ? {{(DATA_WIDTH-8){~zext & sh[7]}}, sh[7:0]} :
             size == SZ_H ? {{(DATA_WIDTH-16){~zext & sh[15]}}, sh[15:0]} :
             size == SZ_W ? {{(DATA_WIDTH-32){~zext & sh[31]}}, sh[31:0]} : word;
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding byte/half/word/double load-store to a 64-bit word memory
// define LSU_MISALIGN_CHECK_EN to reject misaligned accesses instead of truncating the address
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 64
) (
   input  logic                  clk_in,
   input  logic                  reset_n_in,
   input  logic                  req_valid_in,
   output logic                  req_ready_out,
   input  logic                  req_write_in,
   input  logic [1:0]            req_size_in,
   input  logic                  req_unsigned_in,
   input  logic [ADDR_WIDTH-1:0] req_addr_in,
   input  logic [DATA_WIDTH-1:0] req_wdata_in,
   output logic                  resp_valid_out,
   output logic [DATA_WIDTH-1:0] resp_rdata_out,
   output logic                  resp_error_out,
   output logic [ADDR_WIDTH-1:0] mem_address_out,
   output logic [DATA_WIDTH-1:0] mem_data_out,
   input  logic [DATA_WIDTH-1:0] mem_data_in,
   output logic                  mem_writeEnable_out,
   output logic                  mem_readEnable_out
);
   state_e                 state;
   size_e                  size, req_size;
   logic                   write, zext, is_double, sub_store, bad;
   logic [ADDR_WIDTH-1:0]  addr;
   logic [DATA_WIDTH-1:0]  wdata, word, ext, lane_mask, merged;
   logic [OFFSET_BITS-1:0] req_low, off;
   assign req_size = size_e'(req_size_in);
`ifdef LSU_MISALIGN_CHECK_EN
   assign req_low = req_addr_in[OFFSET_BITS-1:0];
   assign bad     = |(req_low & align_mask(req_size));
`else
   assign req_low = req_addr_in[OFFSET_BITS-1:0] & ~align_mask(req_size);
   assign bad     = 1'b0;
`endif
   assign off                 = addr[OFFSET_BITS-1:0];
   assign is_double           = size == SZ_D;
   assign sub_store           = write && !is_double;
   assign req_ready_out       = state == IDLE;
   assign mem_readEnable_out  = state == ACCESS && !(write && is_double);
   assign mem_writeEnable_out = state == WRITE || (state == ACCESS && write && is_double);
   assign mem_address_out     = {addr[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
   assign mem_data_out        = state == WRITE ? word : wdata;
   always_comb begin
      lane_mask = '0;
      for (int k = 0; k < WORD_BYTES; k++)
         lane_mask[8*k+:8] = (k >= int'(off) && k < int'(off) + (1 << size)) ? 8'hFF : 8'h00;
   end
   // read-modify-write merge: untouched lanes keep the memory contents
   assign merged = (mem_data_in & ~lane_mask) | ((wdata << {off, 3'b000}) & lane_mask);
   lsu_load_extract #(.DATA_WIDTH(DATA_WIDTH)) u_extract (
      .word   (mem_data_in),
      .offset (off),
      .size   (size),
      .zext   (zext),
      .data   (ext)
   );
   always_ff @(posedge clk_in or negedge reset_n_in)
      if (!reset_n_in) begin
         state          <= IDLE;
         size           <= SZ_B;
         write          <= 1'b0;
         zext           <= 1'b0;
         addr           <= '0;
         wdata          <= '0;
         word           <= '0;
         resp_valid_out <= 1'b0;
         resp_rdata_out <= '0;
         resp_error_out <= 1'b0;
      end else
         case (state)
            IDLE:
               if (req_valid_in) begin
                  size           <= req_size;
                  write          <= req_write_in;
                  zext           <= req_unsigned_in;
                  wdata          <= req_wdata_in;
                  addr           <= {req_addr_in[ADDR_WIDTH-1:OFFSET_BITS], req_low};
                  resp_rdata_out <= '0;
                  resp_error_out <= bad;
                  resp_valid_out <= bad;
                  state          <= bad ? RESP : ACCESS;
               end
            ACCESS: begin
               word           <= merged;
               resp_rdata_out <= write ? '0 : ext;
               resp_valid_out <= !sub_store;
               state          <= sub_store ? WRITE : RESP;
            end
            WRITE: begin
               resp_valid_out <= 1'b1;
               state          <= RESP;
            end
            RESP: begin
               resp_valid_out <= 1'b0;
               resp_error_out <= 1'b0;
               state          <= IDLE;
            end
         endcase
endmodule
